// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift-leak integration, threshold fire,
// one-step fire state followed by a programmable refractory period.
module lif_neuron #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned REFRAC = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_current,
  input  logic [WIDTH-1:0] threshold,
  input  logic [2:0]       leak_shift,
  output logic [WIDTH-1:0] membrane,
  output logic             spike,
  output logic             refractory,
  output logic [CNT_W-1:0] spike_count
);

  localparam int unsigned RCNT_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam int unsigned SUM_W  = WIDTH + 1;

  typedef enum logic [1:0] {
    S_INT  = 2'd0,
    S_FIRE = 2'd1,
    S_REF  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [RCNT_W-1:0]   rcnt, rcnt_d;
  logic [WIDTH-1:0]    membrane_d;
  logic                spike_d;
  logic [CNT_W-1:0]    count_d;

  logic [WIDTH-1:0]    leak_c;
  logic [SUM_W-1:0]    sum_c;
  logic [WIDTH-1:0]    v_sat_c;
  logic                fire_c;

  // Integration datapath; V - leak cannot underflow since leak <= V
  always_comb begin
    leak_c  = (leak_shift == 3'd0) ? '0 : (membrane >> leak_shift);
    sum_c   = {1'b0, membrane} - {1'b0, leak_c}
            + (in_valid ? {1'b0, in_current} : SUM_W'(0));
    v_sat_c = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
    fire_c  = (threshold != '0) && (v_sat_c >= threshold);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INT;
    end else if (en) begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_INT:   if (fire_c) state_d = S_FIRE;
      S_FIRE:  state_d = (REFRAC > 0) ? S_REF : S_INT;
      S_REF:   if (rcnt == RCNT_W'(1)) state_d = S_INT;
      default: state_d = S_INT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    membrane_d = membrane;
    spike_d    = 1'b0;
    count_d    = spike_count;
    rcnt_d     = rcnt;
    case (state)
      S_INT: begin
        if (fire_c) begin
          membrane_d = '0;
          spike_d    = 1'b1;
          count_d    = spike_count + CNT_W'(1);
        end else begin
          membrane_d = v_sat_c;
        end
      end
      S_FIRE: begin
        membrane_d = '0;
        if (REFRAC > 0) rcnt_d = RCNT_W'(REFRAC);
      end
      S_REF: begin
        membrane_d = '0;
        rcnt_d     = rcnt - RCNT_W'(1);
      end
      default: membrane_d = '0;
    endcase
  end

  // Output registers; spike is a pulse and drops even on a disabled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      membrane    <= '0;
      spike       <= 1'b0;
      refractory  <= 1'b0;
      spike_count <= '0;
      rcnt        <= '0;
    end else if (en) begin
      membrane    <= membrane_d;
      spike       <= spike_d;
      refractory  <= (state_d != S_INT);
      spike_count <= count_d;
      rcnt        <= rcnt_d;
    end else begin
      spike       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron (WIDTH=8, REFRAC=4, CNT_W=8).
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] in_current;
  logic [7:0] threshold;
  logic [2:0] leak_shift;
  logic [7:0] membrane;
  logic       spike;
  logic       refractory;
  logic [7:0] spike_count;

  int compared   = 0;
  int mismatched = 0;

  lif_neuron #(.WIDTH(8), .REFRAC(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in_valid    (in_valid),
    .in_current  (in_current),
    .threshold   (threshold),
    .leak_shift  (leak_shift),
    .membrane    (membrane),
    .spike       (spike),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] m, input logic s,
                         input logic r, input logic [7:0] c);
    chk({tag, ".membrane"},    32'(membrane),    32'(m));
    chk({tag, ".spike"},       32'(spike),       32'(s));
    chk({tag, ".refractory"},  32'(refractory),  32'(r));
    chk({tag, ".spike_count"}, 32'(spike_count), 32'(c));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_current = '0;
    threshold = '0; leak_shift = '0;
    #2;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;

    // Integrate and fire, no leak
    en = 1'b1; threshold = 8'd100; leak_shift = 3'd0;
    in_valid = 1'b1; in_current = 8'd30;
    step(); chk("t1.m1", 32'(membrane), 32'd30);
    step(); chk("t1.m2", 32'(membrane), 32'd60);
    step(); chk("t1.m3", 32'(membrane), 32'd90);
    step(); chk_all("t1.fire", 8'd0, 1'b1, 1'b1, 8'd1);
    step(); chk_all("t1.fire_state", 8'd0, 1'b0, 1'b1, 8'd1);
    in_valid = 1'b0;
    repeat (4) step();
    chk_all("t1.refrac_end", 8'd0, 1'b0, 1'b0, 8'd1);

    // Leak convergence: V settles at 80 with shift 1 and input 40
    apply_reset();
    threshold = 8'd81; leak_shift = 3'd1; in_valid = 1'b1; in_current = 8'd40;
    step(); chk("t2.m1", 32'(membrane), 32'd40);
    step(); chk("t2.m2", 32'(membrane), 32'd60);
    step(); chk("t2.m3", 32'(membrane), 32'd70);
    step(); chk("t2.m4", 32'(membrane), 32'd75);
    step(); chk("t2.m5", 32'(membrane), 32'd78);
    step(); chk("t2.m6", 32'(membrane), 32'd79);
    step(); chk("t2.m7", 32'(membrane), 32'd80);
    step(); chk_all("t2.steady", 8'd80, 1'b0, 1'b0, 8'd0);

    // Saturation with firing disabled
    apply_reset();
    threshold = 8'd0; leak_shift = 3'd0; in_valid = 1'b1; in_current = 8'd200;
    step(); chk("t3.m1", 32'(membrane), 32'd200);
    step(); chk("t3.sat", 32'(membrane), 32'd255);
    step(); chk_all("t3.hold", 8'd255, 1'b0, 1'b0, 8'd0);

    // Refractory timing with continuous drive
    apply_reset();
    threshold = 8'd10; in_current = 8'd20; in_valid = 1'b1;
    step(); chk_all("t4.s1", 8'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 5; i++) begin
      step(); chk_all($sformatf("t4.dead%0d", i), 8'd0, 1'b0, 1'b1, 8'd1);
    end
    step(); chk_all("t4.s6", 8'd0, 1'b0, 1'b0, 8'd1);
    step(); chk_all("t4.s7", 8'd0, 1'b1, 1'b1, 8'd2);

    // en low right after a spike: pulse drops, everything else holds
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all($sformatf("t4.en_low%0d", i), 8'd0, 1'b0, 1'b1, 8'd2);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk($sformatf("t4.stretch%0d", i), 32'(refractory), 32'd1);
    end
    step(); chk_all("t4.stretch_end", 8'd0, 1'b0, 1'b0, 8'd2);
    step(); chk_all("t4.respike", 8'd0, 1'b1, 1'b1, 8'd3);

    // Asynchronous reset during refractory
    step(); step();
    chk("t5.in_refrac", 32'(refractory), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all("t5.async", 8'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(); chk_all("t5.first", 8'd0, 1'b1, 1'b1, 8'd1);

    // Counter wrap: one spike every 6 steps with REFRAC=4
    repeat (6 * 254) step();
    chk_all("t5.cnt255", 8'd0, 1'b1, 1'b1, 8'd255);
    repeat (6) step();
    chk_all("t5.wrap", 8'd0, 1'b1, 1'b1, 8'd0);

    // in_valid gating
    apply_reset();
    threshold = 8'd50; leak_shift = 3'd0; in_current = 8'd30;
    in_valid = 1'b1; step(); chk("t6.m1", 32'(membrane), 32'd30);
    in_valid = 1'b0; step(); chk("t6.m2", 32'(membrane), 32'd30);
    in_valid = 1'b1; step(); chk_all("t6.fire", 8'd0, 1'b1, 1'b1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
